// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM.
// Holds state encodings, opcode constants, ALUOp constants and the
// control-vector struct driven by the output decoder.
package mips_ctrl_pkg;

    localparam int STATE_W = 4;

    // Twelve states are used; 12..15 are unused encodings.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Moore control vector; IllegalOp is not part of it because it also
    // depends on the opcode.
    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/ctrl_output_decoder.sv
// Combinational state -> control-vector lookup for the main control FSM.
// Ports: state_i (current state register), ctrl_o (all Moore enables/selects).
// Unused state encodings produce an all-zero vector, so no write enable fires.
module ctrl_output_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = mips_ctrl_pkg::STATE_W
) (
    input  logic [STATE_W-1:0] state_i,
    output ctrl_t              ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.iord      = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = 2'b01;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_src    = 2'b00;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = 2'b11;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'b10;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                ctrl_o.iord = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'b00;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'b00;
                ctrl_o.alu_op    = ALUOP_SUB;
                ctrl_o.pc_src    = 2'b01;
                ctrl_o.branch    = 1'b1;
            end
            S_ADDIEXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'b10;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl_o.reg_dst    = 1'b0;
                ctrl_o.mem_to_reg = 1'b0;
                ctrl_o.reg_write  = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_src   = 2'b10;
                ctrl_o.pc_write = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/main_control_fsm.sv
// Moore main control FSM for the multicycle MIPS datapath (fetch..writeback).
// Ports: clk/rst_n, Op from the IR; datapath enables, mux selects, ALUOp, IllegalOp.
// Outputs follow the state register; reset forces FETCH asynchronously.
module main_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCWrite,
    output logic       Branch,
    output logic       IllegalOp
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    ctrl_t              ctrl;

    // Op is only looked at in DECODE and MEMADR; the IR cannot change there
    // because it is only loaded in FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTE:  state_d = S_ALUWB;
            S_ADDIEXEC: state_d = S_ADDIWB;
            // Terminal states and unused encodings all return to FETCH.
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    ctrl_output_decoder #(
        .STATE_W (STATE_W)
    ) u_dec (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    assign IorD      = ctrl.iord;
    assign MemWrite  = ctrl.mem_write;
    assign IRWrite   = ctrl.ir_write;
    assign RegDst    = ctrl.reg_dst;
    assign MemtoReg  = ctrl.mem_to_reg;
    assign RegWrite  = ctrl.reg_write;
    assign ALUSrcA   = ctrl.alu_src_a;
    assign ALUSrcB   = ctrl.alu_src_b;
    assign ALUOp     = ctrl.alu_op;
    assign PCSrc     = ctrl.pc_src;
    assign PCWrite   = ctrl.pc_write;
    assign Branch    = ctrl.branch;

    // The only output allowed to see Op: flags an unsupported opcode for the
    // single DECODE cycle before the FSM falls back to FETCH.
    assign IllegalOp = (state_q == S_DECODE) && !op_supported(Op);

endmodule

// File: tb/tb_main_control_fsm.sv
module tb_main_control_fsm;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
        logic       illegal;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCWrite, Branch, IllegalOp;

    main_control_fsm #(.STATE_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Op        (Op),
        .IorD      (IorD),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .PCSrc     (PCSrc),
        .PCWrite   (PCWrite),
        .Branch    (Branch),
        .IllegalOp (IllegalOp)
    );

    always #5 clk = ~clk;

    ctl_t got;
    assign got = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, IllegalOp};

    ctl_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input ctl_t act, input ctl_t req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // ---------------- reference model ----------------
    function automatic bit legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    function automatic ctl_t fetch_vec();
        ctl_t v = '0;
        v.alusrcb = 2'b01;
        v.irwrite = 1'b1;
        v.pcwrite = 1'b1;
        return v;
    endfunction

    // Per-cycle expected control vectors for one whole instruction.
    function automatic int model_push(input logic [5:0] op);
        ctl_t v;
        int   n = 0;
        exp_q.push_back(fetch_vec()); n++;
        v = '0; v.alusrcb = 2'b11; v.illegal = !legal(op);
        exp_q.push_back(v); n++;
        case (op)
            6'b100011, 6'b101011: begin
                v = '0; v.alusrca = 1; v.alusrcb = 2'b10;
                exp_q.push_back(v); n++;
                if (op == 6'b100011) begin
                    v = '0; v.iord = 1;
                    exp_q.push_back(v); n++;
                    v = '0; v.memtoreg = 1; v.regwrite = 1;
                    exp_q.push_back(v); n++;
                end else begin
                    v = '0; v.iord = 1; v.memwrite = 1;
                    exp_q.push_back(v); n++;
                end
            end
            6'b000000: begin
                v = '0; v.alusrca = 1; v.aluop = 2'b10;
                exp_q.push_back(v); n++;
                v = '0; v.regdst = 1; v.regwrite = 1;
                exp_q.push_back(v); n++;
            end
            6'b000100: begin
                v = '0; v.alusrca = 1; v.aluop = 2'b01; v.pcsrc = 2'b01; v.branch = 1;
                exp_q.push_back(v); n++;
            end
            6'b001000: begin
                v = '0; v.alusrca = 1; v.alusrcb = 2'b10;
                exp_q.push_back(v); n++;
                v = '0; v.regwrite = 1;
                exp_q.push_back(v); n++;
            end
            6'b000010: begin
                v = '0; v.pcsrc = 2'b10; v.pcwrite = 1;
                exp_q.push_back(v); n++;
            end
            default: ;
        endcase
        return n;
    endfunction

    // Called on a falling edge while the DUT sits in FETCH.
    task automatic issue(input logic [5:0] op);
        int lat;
        lat = model_push(op);
        Op  = op;
        repeat (lat) @(negedge clk);
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] o;
        case ($urandom_range(0, 6))
            0: o = 6'b100011;
            1: o = 6'b101011;
            2: o = 6'b000000;
            3: o = 6'b000100;
            4: o = 6'b001000;
            5: o = 6'b000010;
            default: begin
                o = 6'($urandom_range(0, 63));
                while (legal(o)) o = 6'($urandom_range(0, 63));
            end
        endcase
        return o;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en && exp_q.size() > 0) begin
                ctl_t e;
                e = exp_q.pop_front();
                check($sformatf("cycle_vec op=%b", Op), got, e);
            end
        end
    end

    task automatic drain();
        int guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] dir_ops [7];
        dir_ops = '{6'b100011, 6'b000000, 6'b101011, 6'b000100,
                    6'b000010, 6'b111111, 6'b001000};
        rst_n = 1'b0;
        Op    = 6'b000000;

        // Reset holds FETCH values.
        repeat (3) begin
            @(negedge clk);
            #1 check("reset_vec", got, fetch_vec());
        end
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        foreach (dir_ops[i]) issue(dir_ops[i]);
        for (int k = 0; k < 40; k++) issue(rand_op());
        drain();
        mon_en = 1'b0;

        // Mid-instruction asynchronous reset while in MEMREAD.
        begin
            ctl_t v;
            Op = 6'b100011;
            repeat (3) @(negedge clk);
            v = '0; v.iord = 1;
            #1 check("lw_memread_before_reset", got, v);
            #1 rst_n = 1'b0;
            #1 check("async_reset_fetch_vals", got, fetch_vec());
            repeat (3) begin
                @(negedge clk);
                #1 check("in_reset_no_regwrite", got, fetch_vec());
            end
            @(negedge clk);
            rst_n  = 1'b1;
            mon_en = 1'b1;
            for (int k = 0; k < 6; k++) issue(rand_op());
            issue(6'b100011);
            drain();
            mon_en = 1'b0;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
